// File: rtl/jumpy_pkg.sv
// Shared types and constants for the jumpy_hawk frame controller:
// state encodings, default frame divider and VGA coordinate widths.
package jumpy_pkg;

    localparam int FRAME_DIV_DEF = 833333;
    localparam int X_W_DEF       = 8;
    localparam int Y_W_DEF       = 7;
    localparam int COL_W_DEF     = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        ERASE      = 3'd2,
        UPDATE     = 3'd3,
        DRAW_WALL  = 3'd4,
        DRAW_BIRD  = 3'd5,
        CHECK      = 3'd6,
        OVER       = 3'd7
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Engine handshake, engine pixel buses, VGA plot port and datapath strobes
// between frame_sequencer (master) and the draw engines/datapath (slave).
interface frame_sequencer_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
) ();
    logic             erase_start, wall_start, bird_start;
    logic             erase_done, wall_done, bird_done;
    logic [X_W-1:0]   erase_x, wall_x, bird_x;
    logic [Y_W-1:0]   erase_y, wall_y, bird_y;
    logic [COL_W-1:0] erase_colour, wall_colour, bird_colour;
    logic             erase_plot, wall_plot, bird_plot;
    logic [X_W-1:0]   x_out;
    logic [Y_W-1:0]   y_out;
    logic [COL_W-1:0] colour_out;
    logic             plot_out;
    logic             update_en, flap;
    logic             collision, wall_passed;

    modport master (
        output erase_start, wall_start, bird_start,
        input  erase_done, wall_done, bird_done,
        input  erase_x, wall_x, bird_x, erase_y, wall_y, bird_y,
        input  erase_colour, wall_colour, bird_colour,
        input  erase_plot, wall_plot, bird_plot,
        output x_out, y_out, colour_out, plot_out,
        output update_en, flap,
        input  collision, wall_passed
    );

    modport slave (
        input  erase_start, wall_start, bird_start,
        output erase_done, wall_done, bird_done,
        output erase_x, wall_x, bird_x, erase_y, wall_y, bird_y,
        output erase_colour, wall_colour, bird_colour,
        output erase_plot, wall_plot, bird_plot,
        input  x_out, y_out, colour_out, plot_out,
        input  update_en, flap,
        output collision, wall_passed
    );
endinterface

// File: rtl/key_press_sync.sv
// Two-flop synchroniser plus falling-edge detect for an active-low push button;
// press is a one-cycle pulse in the cycle after the synchronised edge.
module key_press_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = key_n;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Reset to the released level so coming out of reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign press = prev_q & ~s2_q;
endmodule

// File: rtl/frame_sequencer.sv
// Per-frame game controller: frame tick, phase FSM, plot-port arbitration, score.
// FRAME_SEQ_ERASE_EN enables the ERASE phase; otherwise the tick goes straight to UPDATE.
module frame_sequencer
    import jumpy_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEF,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int COL_W     = COL_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_n,
    frame_sequencer_if.master   bus,
    output logic [7:0]          score,
    output logic                game_over,
    output logic                overrun,
    output logic [2:0]          state
);
    localparam logic [2:0] ST_IDLE       = IDLE;
    localparam logic [2:0] ST_WAIT_FRAME = WAIT_FRAME;
    localparam logic [2:0] ST_ERASE      = ERASE;
    localparam logic [2:0] ST_UPDATE     = UPDATE;
    localparam logic [2:0] ST_DRAW_WALL  = DRAW_WALL;
    localparam logic [2:0] ST_DRAW_BIRD  = DRAW_BIRD;
    localparam logic [2:0] ST_CHECK      = CHECK;
    localparam logic [2:0] ST_OVER       = OVER;

`ifdef FRAME_SEQ_ERASE_EN
    localparam logic [2:0] ST_FIRST = ST_ERASE;
`else
    localparam logic [2:0] ST_FIRST = ST_UPDATE;
`endif

    localparam int             CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);

    logic             press, tick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       state_q, state_d;
    logic [7:0]       score_q, score_d;
    logic             overrun_q, overrun_d;
    logic             flap_q, flap_d;
    logic             wall_start_q, wall_start_d;
    logic             bird_start_q, bird_start_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;

    key_press_sync u_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (press)
    );

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        flap_d    = flap_q;
        // Ticks are not queued: a late frame simply waits for the following tick.
        overrun_d = overrun_q | (tick && state_q != ST_WAIT_FRAME &&
                                 state_q != ST_IDLE && state_q != ST_OVER);
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d   = ST_WAIT_FRAME;
                    score_d   = 8'd0;
                    overrun_d = 1'b0;
                    flap_d    = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (press) flap_d = 1'b1;
                if (tick) state_d = ST_FIRST;
            end
`ifdef FRAME_SEQ_ERASE_EN
            ST_ERASE: begin
                if (press) flap_d = 1'b1;
                if (bus.erase_done) state_d = ST_UPDATE;
            end
`endif
            ST_UPDATE: begin
                // Latch is consumed here; a press in this very cycle carries over.
                flap_d  = press;
                state_d = ST_DRAW_WALL;
            end
            ST_DRAW_WALL: begin
                if (press) flap_d = 1'b1;
                if (bus.wall_done) state_d = ST_DRAW_BIRD;
            end
            ST_DRAW_BIRD: begin
                if (press) flap_d = 1'b1;
                if (bus.bird_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (press) flap_d = 1'b1;
                if (bus.collision) begin
                    state_d = ST_OVER;
                end else begin
                    if (bus.wall_passed) score_d = sat_inc8(score_q);
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_OVER: begin
                if (press) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wall_start_d = (state_d == ST_DRAW_WALL) && (state_q != ST_DRAW_WALL);
        bird_start_d = (state_d == ST_DRAW_BIRD) && (state_q != ST_DRAW_BIRD);
    end

    always_comb begin
        bus.plot_out   = 1'b0;
        bus.x_out      = x_q;
        bus.y_out      = y_q;
        bus.colour_out = col_q;
        case (state_q)
`ifdef FRAME_SEQ_ERASE_EN
            ST_ERASE: begin
                bus.plot_out   = bus.erase_plot;
                bus.x_out      = bus.erase_x;
                bus.y_out      = bus.erase_y;
                bus.colour_out = bus.erase_colour;
            end
`endif
            ST_DRAW_WALL: begin
                bus.plot_out   = bus.wall_plot;
                bus.x_out      = bus.wall_x;
                bus.y_out      = bus.wall_y;
                bus.colour_out = bus.wall_colour;
            end
            ST_DRAW_BIRD: begin
                bus.plot_out   = bus.bird_plot;
                bus.x_out      = bus.bird_x;
                bus.y_out      = bus.bird_y;
                bus.colour_out = bus.bird_colour;
            end
            default: ;
        endcase
        x_d   = bus.x_out;
        y_d   = bus.y_out;
        col_d = bus.colour_out;
    end

`ifdef FRAME_SEQ_ERASE_EN
    logic erase_start_q, erase_start_d;

    assign erase_start_d   = (state_d == ST_ERASE) && (state_q != ST_ERASE);
    assign bus.erase_start = erase_start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) erase_start_q <= 1'b0;
        else       erase_start_q <= erase_start_d;
    end
`else
    logic erase_unused;

    assign bus.erase_start = 1'b0;
    assign erase_unused    = ^{bus.erase_done, bus.erase_x, bus.erase_y,
                               bus.erase_colour, bus.erase_plot};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            score_q      <= 8'd0;
            overrun_q    <= 1'b0;
            flap_q       <= 1'b0;
            wall_start_q <= 1'b0;
            bird_start_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            score_q      <= score_d;
            overrun_q    <= overrun_d;
            flap_q       <= flap_d;
            wall_start_q <= wall_start_d;
            bird_start_q <= bird_start_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
        end
    end

    assign bus.wall_start = wall_start_q;
    assign bus.bird_start = bird_start_q;
    assign bus.update_en  = (state_q == ST_UPDATE);
    assign bus.flap       = (state_q == ST_UPDATE) & flap_q;
    assign score          = score_q;
    assign game_over      = (state_q == ST_OVER);
    assign overrun        = overrun_q;
    assign state          = state_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_DIV=16 and simple engine responders.
module tb_frame_sequencer;
    localparam int FD = 16;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_ERASE = 3'd2, S_UPD = 3'd3,
                           S_WALL = 3'd4, S_BIRD = 3'd5, S_CHK = 3'd6, S_OVER = 3'd7;
`ifdef FRAME_SEQ_ERASE_EN
    localparam logic [2:0] S_FIRST = S_ERASE;
`else
    localparam logic [2:0] S_FIRST = S_UPD;
`endif

    logic       clk = 1'b0;
    logic       reset, key_n;
    logic [7:0] score;
    logic       game_over, overrun;
    logic [2:0] state;
    int         errors = 0, checks = 0;
    int         dly = 3;

    frame_sequencer_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus ();

    frame_sequencer #(.FRAME_DIV(FD), .X_W(8), .Y_W(7), .COL_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .bus       (bus),
        .score     (score),
        .game_over (game_over),
        .overrun   (overrun),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic press_key();
        @(negedge clk);
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        key_n = 1'b1;
    endtask

    // Engine models: done pulse a fixed delay after the start pulse.
    initial begin
        bus.erase_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.erase_start === 1'b1) begin
                repeat (dly - 1) @(negedge clk);
                bus.erase_done = 1'b1;
                @(negedge clk);
                bus.erase_done = 1'b0;
            end
        end
    end

    initial begin
        bus.wall_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wall_start === 1'b1) begin
                repeat (dly - 1) @(negedge clk);
                bus.wall_done = 1'b1;
                @(negedge clk);
                bus.wall_done = 1'b0;
            end
        end
    end

    initial begin
        bus.bird_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.bird_start === 1'b1) begin
                repeat (dly - 1) @(negedge clk);
                bus.bird_done = 1'b1;
                @(negedge clk);
                bus.bird_done = 1'b0;
            end
        end
    end

    initial begin
        int frames;
        reset = 1'b1;
        key_n = 1'b1;
        bus.erase_x = '0; bus.erase_y = '0; bus.erase_colour = '0; bus.erase_plot = 1'b0;
        bus.wall_x  = 8'd7; bus.wall_y = 7'd3; bus.wall_colour = 3'd2; bus.wall_plot = 1'b0;
        bus.bird_x  = '0; bus.bird_y = '0; bus.bird_colour = '0; bus.bird_plot = 1'b0;
        bus.collision   = 1'b0;
        bus.wall_passed = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_outs", 32'({bus.erase_start, bus.wall_start, bus.bird_start, bus.plot_out,
                             bus.update_en, bus.flap, game_over, overrun}), 32'd0);
        chk("rst_xyc", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle40_state", 32'(state), 32'(S_IDLE));
        chk("idle40_ovr", 32'(overrun), 32'd0);

        // Press latency: state changes on the third edge after key_n falls.
        @(posedge clk); #1 key_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 chk("press_lat2", 32'(state), 32'(S_IDLE));
        @(posedge clk); #1 chk("press_lat3", 32'(state), 32'(S_WAIT));
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        chk("start_score", 32'(score), 32'd0);

        // Frame 1: phase sequence and start pulses.
        wait_state(S_FIRST, "f1_first");
`ifdef FRAME_SEQ_ERASE_EN
        chk("f1_erase_start", 32'(bus.erase_start), 32'd1);
`else
        chk("f1_erase_start", 32'(bus.erase_start), 32'd0);
`endif
        wait_state(S_UPD, "f1_upd");
        chk("f1_upd_en", 32'({bus.update_en, bus.flap}), 32'b10);
        wait_state(S_WALL, "f1_wall");
        chk("f1_wall_start", 32'(bus.wall_start), 32'd1);
        wait_state(S_BIRD, "f1_bird");
        chk("f1_bird_start", 32'(bus.bird_start), 32'd1);
        wait_state(S_CHK, "f1_chk");
        wait_state(S_WAIT, "f1_wait");
        chk("f1_score", 32'(score), 32'd1);

        // Frame 2: plot mux in DRAW_BIRD and hold afterwards.
        wait_state(S_BIRD, "f2_bird");
        bus.wall_plot = 1'b1; bus.bird_plot = 1'b0;
        #1 chk("mux_wall_in_bird", 32'(bus.plot_out), 32'd0);
        bus.bird_plot = 1'b1; bus.bird_x = 8'd42;
        #1 chk("mux_bird_plot", 32'(bus.plot_out), 32'd1);
        chk("mux_bird_x", 32'(bus.x_out), 32'd42);
        wait_state(S_CHK, "f2_chk");
        chk("mux_chk_plot", 32'(bus.plot_out), 32'd0);
        chk("mux_hold_x", 32'(bus.x_out), 32'd42);
        bus.wall_plot = 1'b0; bus.bird_plot = 1'b0; bus.bird_x = 8'd0;
        wait_state(S_WAIT, "f2_wait");
        chk("f2_score", 32'(score), 32'd2);
        chk("f2_ovr", 32'(overrun), 32'd0);

        // Frame 3: press during DRAW_WALL; frame 4 flaps, frame 5 does not.
        wait_state(S_WALL, "f3_wall");
        press_key();
        wait_state(S_UPD, "f4_upd");
        chk("f4_flap", 32'({bus.update_en, bus.flap}), 32'b11);
        wait_state(S_WALL, "f4_wall");
        wait_state(S_UPD, "f5_upd");
        chk("f5_flap", 32'({bus.update_en, bus.flap}), 32'b10);

        // Frame 5: collision beats wall_passed.
        bus.collision = 1'b1;
        wait_state(S_OVER, "f5_over");
        bus.collision = 1'b0;
        chk("over_go", 32'(game_over), 32'd1);
        chk("over_score", 32'(score), 32'd4);
        press_key();
        wait_state(S_IDLE, "over_idle");
        chk("idle_score", 32'(score), 32'd4);
        chk("idle_go", 32'(game_over), 32'd0);
        press_key();
        wait_state(S_WAIT, "restart_wait");
        chk("restart_score", 32'(score), 32'd0);

        // Saturation at 255.
        frames = 0;
        while (score !== 8'd255 && frames < 300) begin
            wait_state(S_CHK, "sat_chk");
            wait_state(S_WAIT, "sat_wait");
            frames++;
        end
        chk("sat_frames", 32'(frames), 32'd255);
        wait_state(S_CHK, "sat1_chk");
        wait_state(S_WAIT, "sat1_wait");
        chk("sat_score", 32'(score), 32'd255);
        chk("sat_ovr", 32'(overrun), 32'd0);

        // Overrun: engines slower than a frame.
        dly = 20;
        wait_state(S_WALL, "ovr_wall");
        wait_state(S_WAIT, "ovr_wait");
        chk("ovr_set", 32'(overrun), 32'd1);
        dly = 3;
        wait_state(S_CHK, "ovr2_chk");
        wait_state(S_WAIT, "ovr2_wait");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_score", 32'(score), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the jumpy_hawk game. Generates the frame tick from the 50 MHz clock and steps the game through erase, physics update, wall draw, bird draw and collision check once per frame. Shares the single vga_adapter plot port between the erase, wall and bird drawing engines. Owns the 8-bit score and the game-over state that feed the HEX displays.

## Interface
- FRAME_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); minimum 16
- X_W, 8, x coordinate width (160-column mode)
- Y_W, 7, y coordinate width (120-row mode)
- COL_W, 3, colour width
- clk  in  1  system clock, CLOCK_50
- reset  in  1  asynchronous, active-high reset
- key_n  in  1  player button, active-low (KEY[0]), asynchronous to clk
- erase_start / wall_start / bird_start  out  1 each  one-cycle start pulse to the matching draw engine
- erase_done / wall_done / bird_done  in  1 each  one-cycle completion pulse from the matching engine
- {erase,wall,bird}_x  in  X_W; {erase,wall,bird}_y  in  Y_W; {erase,wall,bird}_colour  in  COL_W; {erase,wall,bird}_plot  in  1  engine pixel outputs
- x_out  out  X_W; y_out  out  Y_W; colour_out  out  COL_W; plot_out  out  1  to vga_adapter
- update_en  out  1  one-cycle pulse: datapath advances bird/wall positions
- flap  out  1  valid with update_en: a press occurred since the last update
- collision  in  1  datapath collision flag, valid in CHECK
- wall_passed  in  1  datapath flag, valid in CHECK
- score  out  8  binary score to hex decoders
- game_over  out  1  high in OVER
- overrun  out  1  sticky: a frame tick arrived outside WAIT_FRAME
- state  out  3  current state encoding, debug

## Operation
- key_n: 2-flop synchroniser, then falling-edge detect -> press pulse (1 cycle).
- States: IDLE, WAIT_FRAME, ERASE, UPDATE, DRAW_WALL, DRAW_BIRD, CHECK, OVER.
- IDLE: press -> clear score, clear overrun, go WAIT_FRAME.
- WAIT_FRAME: frame tick -> ERASE.
- ERASE: erase_start pulses on entry; erase_done -> UPDATE.
- UPDATE: update_en pulses for one cycle with flap; flap latch clears; -> DRAW_WALL next cycle.
- DRAW_WALL: wall_start on entry; wall_done -> DRAW_BIRD. DRAW_BIRD: bird_start on entry; bird_done -> CHECK.
- CHECK (one cycle): collision -> OVER; otherwise wall_passed increments score, saturating at 255, and the state -> WAIT_FRAME. When collision and wall_passed are both high, collision wins and the score is not incremented.
- OVER: game_over high; press -> IDLE.
- Flap latch: set by press in ERASE, DRAW_*, CHECK or WAIT_FRAME. A press that coincides with update_en is held for the next frame.
- Plot mux: ERASE forwards erase_* signals; DRAW_WALL forwards wall_*; DRAW_BIRD forwards bird_*. In every other state plot_out=0, and x/y/colour hold their last value.
- A done pulse from a non-granted engine is ignored.
- Frame counter: free-running 0..FRAME_DIV-1. The tick is the wrap cycle. A tick in any state other than WAIT_FRAME, IDLE or OVER sets overrun. The sequence then waits for the next tick; ticks are never queued.

## Timing
- Reset: state=IDLE, all outputs 0, score=0, frame counter=0, flap latch=0.
- Press to state change: 3 cycles after key_n falls, made up of 2 sync cycles and 1 edge-detect cycle.
- Start pulses are asserted in the first cycle of the state and registered.
- done in cycle n -> next state in cycle n+1.
- Plot mux is combinational from the registered state, with zero added latency.
- Minimum frame length is 5 cycles plus engine draw times.
- Reset mid-frame aborts immediately. Engines are expected to be reset by the same reset.

## Configuration
- FRAME_SEQ_ERASE_EN defined: ERASE phase present as described.
- Not defined:
  - WAIT_FRAME tick goes directly to UPDATE.
  - erase_start is tied 0.
  - erase_* inputs are unused.
  - Used for full-screen-redraw engines that overwrite the background themselves.

## Structure
- Package jumpy_pkg holds:
  - the state enum, with fixed encodings IDLE=0, WAIT_FRAME=1, ERASE=2, UPDATE=3, DRAW_WALL=4, DRAW_BIRD=5, CHECK=6, OVER=7
  - the default FRAME_DIV
  - the coordinate width constants
- Sub-module key_press_sync: synchroniser plus falling-edge detect, reusable for KEY[1..3].

## Test plan
- Reset, FRAME_DIV=16, key_n=1 -> state=IDLE, all outputs 0; 40 cycles later still IDLE, overrun=0.
- Press, then engines return done 3 cycles after each start, collision=0, wall_passed=1 -> states sequence ERASE/UPDATE/DRAW_WALL/DRAW_BIRD/CHECK; score increments 0->1->2 over 2 frames.
- Plot mux: wall_plot=1 while in DRAW_BIRD -> plot_out=0; bird_plot=1, bird_x=8'd42 -> plot_out=1, x_out=42.
- Press during DRAW_WALL -> next frame's update_en has flap=1; the frame after has flap=0 with no press.
- collision=1 with wall_passed=1 in CHECK -> OVER, game_over=1, score unchanged. Press -> IDLE. Press again -> score=0.
- Score at 255 with wall_passed=1 -> score stays 255. Engine done delayed 20 cycles with FRAME_DIV=16 -> overrun=1 and stays 1.
